// File: rtl/qk_score_reduce_if.sv
// Handshake bundle between the vector multiplier, the QK score reducer and the softmax stage.
// The slave modport is the reducer's view of the bundle.
interface qk_score_reduce_if #(
  parameter int unsigned VECTDEPTH  = 64,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_WORDS  = 32
);
  logic                            in_valid;
  logic                            in_ready;
  logic [VECTDEPTH*DATA_WIDTH-1:0] products;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_WORDS*DATA_WIDTH-1:0] scores;

  modport master (
    output in_valid, products, out_ready,
    input  in_ready, out_valid, scores
  );

  modport slave (
    input  in_valid, products, out_ready,
    output in_ready, out_valid, scores
  );
endinterface

// File: rtl/qk_score_reduce.sv
// QK score reducer: pipelined adder tree, arithmetic scale-down, narrowing, row buffer with handoff.
// Optional clamping of the narrowed score is enabled by defining SCORE_SAT_EN.
module qk_score_reduce #(
  parameter int unsigned VECTDEPTH   = 64,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned NUM_WORDS   = 32,
  parameter int unsigned SCALE_SHIFT = 3,
  parameter int unsigned ACC_WIDTH   = 22
) (
  input logic               clk,
  input logic               reset,
  qk_score_reduce_if.slave  bus
);

  localparam int unsigned LEVELS  = $clog2(VECTDEPTH);
  localparam int unsigned NODES   = VECTDEPTH - 1;
  localparam int unsigned ISSUE_W = $clog2(NUM_WORDS + 1);
  localparam int unsigned WR_W    = $clog2(NUM_WORDS);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [ISSUE_W-1:0]           issue_cnt_q, issue_cnt_d;
  logic [WR_W-1:0]              wr_cnt_q, wr_cnt_d;
  logic [LEVELS:0]              vld_q;
  logic signed [ACC_WIDTH-1:0]  leaf_q [VECTDEPTH];
  logic signed [ACC_WIDTH-1:0]  leaf_d [VECTDEPTH];
  logic signed [ACC_WIDTH-1:0]  node_q [NODES];
  logic signed [ACC_WIDTH-1:0]  node_d [NODES];
  logic signed [ACC_WIDTH-1:0]  tree_c [2*VECTDEPTH-1];
  logic [DATA_WIDTH-1:0]        score_q [NUM_WORDS];
  logic signed [ACC_WIDTH-1:0]  shifted_c;
  logic [DATA_WIDTH-1:0]        narrow_c;
  logic                         in_ready_c;
  logic                         accept_c;
  logic                         write_c;

  assign in_ready_c    = (state_q == ST_FILL) && (issue_cnt_q < ISSUE_W'(NUM_WORDS));
  assign accept_c      = bus.in_valid && in_ready_c;
  assign write_c       = vld_q[LEVELS];
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == ST_FULL);

  // Heap-ordered tree: nodes 0..NODES-1 are registered sums, the leaves follow them.
  always_comb begin
    for (int i = 0; i < VECTDEPTH; i++) begin
      leaf_d[i] = {{(ACC_WIDTH-DATA_WIDTH){bus.products[i*DATA_WIDTH+DATA_WIDTH-1]}},
                   bus.products[i*DATA_WIDTH +: DATA_WIDTH]};
    end
    for (int n = 0; n < NODES; n++) begin
      tree_c[n] = node_q[n];
    end
    for (int i = 0; i < VECTDEPTH; i++) begin
      tree_c[NODES+i] = leaf_q[i];
    end
    for (int n = 0; n < NODES; n++) begin
      node_d[n] = tree_c[2*n+1] + tree_c[2*n+2];
    end
  end

  assign shifted_c = node_q[0] >>> SCALE_SHIFT;

`ifdef SCORE_SAT_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX_W = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN_W = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, SAT_MAX_W};
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = {{(ACC_WIDTH-DATA_WIDTH){1'b1}}, SAT_MIN_W};

  always_comb begin
    narrow_c = shifted_c[DATA_WIDTH-1:0];
    if (shifted_c > SAT_HI) begin
      narrow_c = SAT_MAX_W;
    end else if (shifted_c < SAT_LO) begin
      narrow_c = SAT_MIN_W;
    end
  end
`else
  logic unused_shift_hi;
  assign narrow_c        = shifted_c[DATA_WIDTH-1:0];
  assign unused_shift_hi = ^shifted_c[ACC_WIDTH-1:DATA_WIDTH];
`endif

  // Row FSM and counters.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    case (state_q)
      ST_FILL: begin
        if (accept_c) begin
          issue_cnt_d = issue_cnt_q + ISSUE_W'(1);
        end
        if (write_c) begin
          if (wr_cnt_q == WR_W'(NUM_WORDS - 1)) begin
            state_d = ST_FULL;
          end else begin
            wr_cnt_d = wr_cnt_q + WR_W'(1);
          end
        end
      end
      ST_FULL: begin
        if (bus.out_ready) begin
          state_d     = ST_FILL;
          issue_cnt_d = '0;
          wr_cnt_d    = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_FILL;
      issue_cnt_q <= '0;
      wr_cnt_q    <= '0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      vld_q       <= {vld_q[LEVELS-1:0], accept_c};
    end
  end

  // The tree never stalls, so data registers advance every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < VECTDEPTH; i++) leaf_q[i] <= '0;
      for (int n = 0; n < NODES; n++)     node_q[n] <= '0;
      for (int k = 0; k < NUM_WORDS; k++) score_q[k] <= '0;
    end else begin
      for (int i = 0; i < VECTDEPTH; i++) leaf_q[i] <= leaf_d[i];
      for (int n = 0; n < NODES; n++)     node_q[n] <= node_d[n];
      if (write_c) begin
        score_q[wr_cnt_q] <= narrow_c;
      end
    end
  end

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_scores
    assign bus.scores[k*DATA_WIDTH +: DATA_WIDTH] = score_q[k];
  end

endmodule

// File: tb/tb_qk_score_reduce.sv
// Directed-plus-random bench for qk_score_reduce with an arithmetic reference model of each score.
module tb_qk_score_reduce;

  localparam int unsigned V  = 64;
  localparam int unsigned DW = 16;
  localparam int unsigned NW = 32;

  logic clk;
  logic reset;

  qk_score_reduce_if #(.VECTDEPTH(V), .DATA_WIDTH(DW), .NUM_WORDS(NW)) bus ();

  qk_score_reduce #(
    .VECTDEPTH(V), .DATA_WIDTH(DW), .NUM_WORDS(NW), .SCALE_SHIFT(3), .ACC_WIDTH(22)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q [$];

  function automatic logic [15:0] model(input logic [V*DW-1:0] p);
    int sum;
    sum = 0;
    for (int i = 0; i < V; i++) sum += int'($signed(p[i*DW +: DW]));
    sum = sum >>> 3;
`ifdef SCORE_SAT_EN
    if (sum > 32767)  return 16'h7FFF;
    if (sum < -32768) return 16'h8000;
`endif
    return sum[15:0];
  endfunction

  function automatic logic [V*DW-1:0] splat(input logic [15:0] v);
    logic [V*DW-1:0] p;
    for (int i = 0; i < V; i++) p[i*DW +: DW] = v;
    return p;
  endfunction

  function automatic logic [V*DW-1:0] rand_beat();
    logic [V*DW-1:0] p;
    for (int i = 0; i < V; i++) p[i*DW +: DW] = 16'($urandom);
    return p;
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; the model queue records accepted beats.
  task automatic send_beat(input logic [V*DW-1:0] p);
    int b;
    bus.in_valid = 1'b1;
    bus.products = p;
    b = 0;
    while (!bus.in_ready && b < 64) begin
      tick();
      b++;
    end
    check("beat_accept", 512'(bus.in_ready), 512'(1));
    if (bus.in_ready) exp_q.push_back(model(p));
    tick();
  endtask

  task automatic wait_out_valid(input string tag);
    int b;
    b = 0;
    while (!bus.out_valid && b < 64) begin
      tick();
      b++;
    end
    check(tag, 512'(bus.out_valid), 512'(1));
  endtask

  task automatic check_row(input string tag);
    logic [15:0] e;
    for (int k = 0; k < NW; k++) begin
      e = (k < exp_q.size()) ? exp_q[k] : 16'hxxxx;
      check($sformatf("%s_score%0d", tag, k), 512'(bus.scores[k*DW +: DW]), 512'(e));
    end
  endtask

  task automatic handoff();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.products  = '0;
    reset         = 1'b0;
    repeat (3) tick();
    check("reset_out_valid", 512'(bus.out_valid), 512'(0));
    check("reset_scores", 512'(bus.scores), 512'(0));
    reset = 1'b1;
    tick();
    check("reset_in_ready", 512'(bus.in_ready), 512'(1));

    // Single beat latency: accepted at E0, score lands at E7.
    send_beat(splat(16'h0001));
    bus.in_valid = 1'b0;
    repeat (6) tick();
    check("latency_e6_score0", 512'(bus.scores[15:0]), 512'(0));
    tick();
    check("latency_e7_score0", 512'(bus.scores[15:0]), 512'(16'h0008));
    check("latency_e7_out_valid", 512'(bus.out_valid), 512'(0));

    // Narrowing boundaries, then random beats to complete the row.
    send_beat(splat(16'h7FFF));
    send_beat(splat(16'h8000));
    for (int k = 3; k < NW; k++) send_beat(rand_beat());
    bus.in_valid = 1'b0;
    wait_out_valid("row1_out_valid");
`ifdef SCORE_SAT_EN
    check("max_lanes", 512'(bus.scores[31:16]), 512'(16'h7FFF));
    check("min_lanes", 512'(bus.scores[47:32]), 512'(16'h8000));
`else
    check("max_lanes", 512'(bus.scores[31:16]), 512'(16'hFFF8));
    check("min_lanes", 512'(bus.scores[47:32]), 512'(16'h0000));
`endif
    check_row("row1");

    // Backpressure: pending beats are ignored while the row is held.
    bus.in_valid = 1'b1;
    bus.products = splat(16'h1234);
    for (int j = 0; j < 10; j++) begin
      tick();
      check($sformatf("bp_in_ready%0d", j), 512'(bus.in_ready), 512'(0));
      check($sformatf("bp_out_valid%0d", j), 512'(bus.out_valid), 512'(1));
    end
    check_row("bp_hold");
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    exp_q.delete();
    check("handoff_out_valid", 512'(bus.out_valid), 512'(0));
    check("handoff_in_ready", 512'(bus.in_ready), 512'(1));

    // Back-to-back ramp row: beat k has every lane equal to k.
    for (int k = 0; k < NW; k++) send_beat(splat(16'(k)));
    check("ramp_in_ready_low", 512'(bus.in_ready), 512'(0));
    bus.in_valid = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      if (j == 6) check("ramp_out_valid_early", 512'(bus.out_valid), 512'(0));
      if (j == 7) check("ramp_out_valid_rise", 512'(bus.out_valid), 512'(1));
    end
    for (int k = 0; k < NW; k++)
      check($sformatf("ramp_score%0d", k), 512'(bus.scores[k*DW +: DW]), 512'(16'(8*k)));
    handoff();

    // Reset in the middle of a row discards everything.
    for (int k = 0; k < 10; k++) send_beat(rand_beat());
    bus.in_valid = 1'b0;
    repeat (8) tick();
    #2;
    reset = 1'b0;
    #1;
    check("midreset_out_valid", 512'(bus.out_valid), 512'(0));
    check("midreset_scores", 512'(bus.scores), 512'(0));
    tick();
    reset = 1'b1;
    exp_q.delete();
    tick();
    check("midreset_in_ready", 512'(bus.in_ready), 512'(1));
    for (int k = 0; k < NW - 1; k++) send_beat(rand_beat());
    bus.in_valid = 1'b0;
    repeat (12) tick();
    check("midreset_not_full", 512'(bus.out_valid), 512'(0));
    send_beat(rand_beat());
    bus.in_valid = 1'b0;
    wait_out_valid("midreset_out_valid_rise");
    check_row("midreset_row");
    handoff();
    check("final_out_valid", 512'(bus.out_valid), 512'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
